// File: rtl/td4_core_p.sv
// td4_core_p: parametrised single-cycle TD4-class CPU core.
//
// Each rising clk with instr_valid high (and the core not halted) executes
// the instruction presented at pc_o by an external ROM. All architectural
// state is registered and becomes visible the cycle after execution.
//
// Parameters:
//   DATA_W  width of A, B, OUT, IN and the immediate field (4..16)
//   PC_W    program-counter width, ROM depth 2^PC_W (4..DATA_W)
//
// Optional feature macro: TD4_HALT_EN
//   defined   -> opcode 1101 is HLT; halted_o freezes the core until reset
//   undefined -> opcode 1101 is a NOP; halted_o is tied to 0
//
// Ports:
//   clk           core clock, rising edge
//   rst_n         asynchronous active-low reset
//   instr_opcode  opcode of the instruction at pc_o
//   instr_imm     immediate of the instruction at pc_o
//   instr_valid   instruction fields valid this cycle; low stalls the core
//   in_port       external input port, sampled by IN A / IN B
//   pc_o          program counter / ROM address
//   reg_a_o       register A
//   reg_b_o       register B
//   out_port      output register
//   carry_o       carry flag
//   halted_o      core halted
module td4_core_p #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned PC_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        instr_opcode,
    input  logic [DATA_W-1:0] instr_imm,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] in_port,
    output logic [PC_W-1:0]   pc_o,
    output logic [DATA_W-1:0] reg_a_o,
    output logic [DATA_W-1:0] reg_b_o,
    output logic [DATA_W-1:0] out_port,
    output logic              carry_o,
    output logic              halted_o
);

    localparam logic [3:0] OpAddA  = 4'b0000;
    localparam logic [3:0] OpMovAB = 4'b0001;
    localparam logic [3:0] OpInA   = 4'b0010;
    localparam logic [3:0] OpMovAI = 4'b0011;
    localparam logic [3:0] OpMovBA = 4'b0100;
    localparam logic [3:0] OpAddB  = 4'b0101;
    localparam logic [3:0] OpInB   = 4'b0110;
    localparam logic [3:0] OpMovBI = 4'b0111;
    localparam logic [3:0] OpOutB  = 4'b1001;
    localparam logic [3:0] OpOutI  = 4'b1011;
    localparam logic [3:0] OpJnc   = 4'b1110;
    localparam logic [3:0] OpJmp   = 4'b1111;
`ifdef TD4_HALT_EN
    localparam logic [3:0] OpHlt   = 4'b1101;
`endif

    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              carry_q, carry_d;
    logic              exec;

    // One extra bit on each adder captures the DATA_W-bit carry-out.
    logic [DATA_W:0]   sum_a;
    logic [DATA_W:0]   sum_b;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   jmp_tgt;

    assign sum_a   = {1'b0, a_q} + {1'b0, instr_imm};
    assign sum_b   = {1'b0, b_q} + {1'b0, instr_imm};
    assign pc_inc  = pc_q + PC_W'(1);
    assign jmp_tgt = instr_imm[PC_W-1:0];

`ifdef TD4_HALT_EN
    logic halted_q, halted_d;
    assign exec     = instr_valid & ~halted_q;
    assign halted_o = halted_q;
`else
    assign exec     = instr_valid;
    assign halted_o = 1'b0;
`endif

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        out_d    = out_q;
        pc_d     = pc_q;
        carry_d  = carry_q;
`ifdef TD4_HALT_EN
        halted_d = halted_q;
`endif
        if (exec) begin
            // Every executed instruction clears carry unless it is an ADD.
            pc_d    = pc_inc;
            carry_d = 1'b0;
            case (instr_opcode)
                OpAddA:  {carry_d, a_d} = sum_a;
                OpMovAB: a_d = b_q;
                OpInA:   a_d = in_port;
                OpMovAI: a_d = instr_imm;
                OpMovBA: b_d = a_q;
                OpAddB:  {carry_d, b_d} = sum_b;
                OpInB:   b_d = in_port;
                OpMovBI: b_d = instr_imm;
                OpOutB:  out_d = b_q;
                OpOutI:  out_d = instr_imm;
                OpJnc: begin
                    // Tests the flag left by the previous instruction.
                    if (!carry_q) begin
                        pc_d = jmp_tgt;
                    end
                end
                OpJmp:   pc_d = jmp_tgt;
`ifdef TD4_HALT_EN
                OpHlt: begin
                    // pc stays on the HLT so a debugger sees where it stopped.
                    pc_d     = pc_q;
                    halted_d = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            out_q    <= '0;
            pc_q     <= '0;
            carry_q  <= 1'b0;
`ifdef TD4_HALT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            out_q    <= out_d;
            pc_q     <= pc_d;
            carry_q  <= carry_d;
`ifdef TD4_HALT_EN
            halted_q <= halted_d;
`endif
        end
    end

    assign pc_o     = pc_q;
    assign reg_a_o  = a_q;
    assign reg_b_o  = b_q;
    assign out_port = out_q;
    assign carry_o  = carry_q;

endmodule

// File: doc/td4_core_p.md
Name: td4_core_p

Overview:
- Parametrised TD4-class 4-bit-family CPU core; the next generation of the team's minimal CPU.
- Full TD4 instruction set:
  - ADD/MOV on registers A and B
  - IN and OUT ports
  - JMP and JNC with a real carry flag
- Generalised in data width (DATA_W) and program-counter width (PC_W).
- External instruction ROM, addressed by pc_o, supplies one instruction per cycle; an instr_valid input lets a slow ROM stall the core.

Parameters:
- DATA_W, 4: width of A, B, OUT, IN and immediate field. Legal range 4..16.
- PC_W, 4: program-counter width; ROM depth is 2^PC_W. Legal range 4..DATA_W.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_opcode  input  4  opcode of instruction at pc_o.
- instr_imm  input  DATA_W  immediate of instruction at pc_o.
- instr_valid  input  1  instruction fields valid this cycle; low = stall.
- in_port  input  DATA_W  external input port, sampled by IN.
- pc_o  output  PC_W  current program counter / ROM address.
- reg_a_o  output  DATA_W  register A.
- reg_b_o  output  DATA_W  register B.
- out_port  output  DATA_W  output register.
- carry_o  output  1  carry flag.
- halted_o  output  1  core halted; tied 0 without TD4_HALT_EN.

Behaviour:
- Reset (async, rst_n low): A, B, out_port, pc, carry and halted all 0, immediately, regardless of clock.
- Execution model:
  - Single cycle. On each rising clk with instr_valid=1 and not halted, the instruction at pc_o executes and all state updates at that edge.
  - instr_valid=0: no state changes, including pc and carry.
- Opcodes (Im = instr_imm):
  - 0000 ADD A,Im: {c,A} <= A+Im
  - 0001 MOV A,B
  - 0010 IN A: A <= in_port
  - 0011 MOV A,Im
  - 0100 MOV B,A
  - 0101 ADD B,Im: {c,B} <= B+Im
  - 0110 IN B
  - 0111 MOV B,Im
  - 1001 OUT B: out_port <= B
  - 1011 OUT Im
  - 1110 JNC Im
  - 1111 JMP Im
  - 1000, 1010, 1100, 1101 are NOP (1101 repurposed under macro).
- Carry:
  - ADD sets carry to the DATA_W-bit carry-out.
  - Every other executed instruction, NOPs included, clears carry to 0.
  - Stall cycles hold carry.
- Arithmetic:
  - Modulo 2^DATA_W.
  - Immediate used at full DATA_W width; no sign extension.
- PC:
  - Non-jump instructions: pc <= pc+1, wrapping from 2^PC_W-1 to 0.
  - JMP: pc <= Im[PC_W-1:0].
  - JNC: if carry (the value before this edge) == 0, pc <= Im[PC_W-1:0]; else pc+1.
- Register writes and the outputs reg_a_o, reg_b_o, out_port and carry_o are all registered, visible the cycle after execution.
- in_port is sampled only at the executing edge; no synchronisation is performed inside the core.
- Reset asserted mid-stream: all state returns to 0 at once; on release, execution restarts at pc 0 with the first valid cycle.

Optional Feature:
- Macro: TD4_HALT_EN.
- Defined:
  - Opcode 1101 = HLT. Executing it sets halted_o=1 and leaves pc pointing at the HLT (no increment), with carry cleared.
  - While halted, all state is frozen and instr_valid is ignored.
  - Only reset clears halted_o.
- Undefined:
  - 1101 is a NOP (pc+1, carry cleared).
  - halted_o is constant 0.

Test Plan:
- Reset:
  - Stimulus: drive arbitrary state, then pulse rst_n low between clock edges.
  - Required: all outputs read 0 before the next edge; pc_o=0.
- Add with carry, DATA_W=4:
  - Stimulus: MOV A,0xE; ADD A,0x3; JNC 0x0; MOV B,0x5.
  - Required: A=0x1 and carry=1 after ADD; JNC not taken (pc=3); B=5 and carry=0 after MOV.
- Loop and wrap, PC_W=4:
  - Stimulus: 16 consecutive NOPs.
  - Required: pc walks 0..15 then back to 0; carry stays 0.
- IN/OUT and stall:
  - Stimulus: in_port=0x9, IN B, then OUT B with instr_valid low for 3 cycles before the OUT.
  - Required: B=9; pc, out_port and carry unchanged during the stall; out_port=9 one edge after valid returns.
- Wide config, DATA_W=8, PC_W=6:
  - Stimulus: ADD A,0xFF from A=0x01; then JMP 0xC5.
  - Required: A=0x00, carry=1; pc=0x05 (truncated immediate).
- HLT (TD4_HALT_EN defined):
  - Stimulus: MOV A,0x7; HLT; then keep clocking with valid=1.
  - Required: halted_o=1, pc stays at 1, A stays 7; rst_n pulse returns everything to 0.
  - Without the macro: HLT acts as NOP and pc advances to 2.
